// File: rtl/rect_pkg.sv
// Shared types and constants for the bounding-box overlay (rect_latch, rect_overlay).
package rect_pkg;

    localparam int          COORD_W       = 11;
    localparam logic [10:0] IMG_HDISP_DEF = 11'd1024;
    localparam logic [10:0] IMG_VDISP_DEF = 11'd768;

    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t up;
        coord_t down;
        coord_t left;
        coord_t right;
    } rect_t;

endpackage

// File: rtl/rect_latch.sv
// Captures the detector box on each vsync rising edge and tracks missed frames.
// With RECT_CROSSHAIR_EN defined it also registers the box centre at the same edge.
module rect_latch
    import rect_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP   = IMG_HDISP_DEF,
    parameter logic [2:0]  HOLD_FRAMES = 3'd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic [10:0]          rect_up,
    input  logic [10:0]          rect_down,
    input  logic [10:0]          rect_left,
    input  logic [10:0]          rect_right,
    input  logic                 rect_flag,
`ifdef RECT_CROSSHAIR_EN
    output logic [10:0]          cx,
    output logic [10:0]          cy,
`endif
    output logic [4*COORD_W-1:0] rect_q,
    output logic                 box_active
);

    logic       vsync_d;
    logic       vs_rise;
    logic       box_valid;
    logic [2:0] miss_cnt;
    logic [3:0] miss_inc;

    assign vs_rise   = vsync & ~vsync_d;
    assign box_valid = rect_flag && (rect_up <= rect_down) &&
                       (rect_left <= rect_right) && (rect_right < IMG_HDISP);

    // Saturating increment, widened so HOLD_FRAMES = 7 cannot wrap.
    always_comb begin
        miss_inc = {1'b0, miss_cnt} + 4'd1;
        if ({1'b0, miss_cnt} >= {1'b0, HOLD_FRAMES})
            miss_inc = {1'b0, HOLD_FRAMES};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            rect_q     <= '0;
            miss_cnt   <= 3'd0;
            box_active <= 1'b0;
        end else begin
            vsync_d <= vsync;
            if (vs_rise) begin
                if (box_valid) begin
                    rect_q     <= {rect_up, rect_down, rect_left, rect_right};
                    miss_cnt   <= 3'd0;
                    box_active <= 1'b1;
                end else begin
                    miss_cnt <= miss_inc[2:0];
                    if (miss_inc == {1'b0, HOLD_FRAMES})
                        box_active <= 1'b0;
                end
            end
        end
    end

`ifdef RECT_CROSSHAIR_EN
    logic [11:0] sum_v;
    logic [11:0] sum_h;

    assign sum_v = {1'b0, rect_up} + {1'b0, rect_down};
    assign sum_h = {1'b0, rect_left} + {1'b0, rect_right};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cx <= 11'd0;
            cy <= 11'd0;
        end else if (vs_rise && box_valid) begin
            cx <= sum_h[11:1];
            cy <= sum_v[11:1];
        end
    end
`endif

endmodule

// File: rtl/rect_overlay.sv
// Draws the latched detector box as a coloured border onto an RGB565 stream, 1-cycle latency.
// Optional crosshair at the box centre when RECT_CROSSHAIR_EN is defined.
module rect_overlay
    import rect_pkg::*;
#(
    parameter logic [10:0] IMG_HDISP   = IMG_HDISP_DEF,
    parameter logic [10:0] IMG_VDISP   = IMG_VDISP_DEF,
    parameter logic [3:0]  LINE_W      = 4'd2,
    parameter logic [15:0] BOX_COLOR   = RGB565_RED,
    parameter logic [2:0]  HOLD_FRAMES = 3'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [15:0] per_img_data,
    input  logic [10:0] rect_up,
    input  logic [10:0] rect_down,
    input  logic [10:0] rect_left,
    input  logic [10:0] rect_right,
    input  logic        rect_flag,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [15:0] post_img_data,
    output logic        box_active
);

    logic [4*COORD_W-1:0] rect_q;
    rect_t                box;
    logic [10:0]          x_cnt;
    logic [10:0]          y_cnt;

`ifdef RECT_CROSSHAIR_EN
    logic [10:0] cx;
    logic [10:0] cy;
`endif

    rect_latch #(
        .IMG_HDISP   (IMG_HDISP),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_latch (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (per_frame_vsync),
        .rect_up    (rect_up),
        .rect_down  (rect_down),
        .rect_left  (rect_left),
        .rect_right (rect_right),
        .rect_flag  (rect_flag),
`ifdef RECT_CROSSHAIR_EN
        .cx         (cx),
        .cy         (cy),
`endif
        .rect_q     (rect_q),
        .box_active (box_active)
    );

    assign box = rect_t'(rect_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= 11'd0;
            y_cnt <= 11'd0;
        end else if (per_frame_vsync) begin
            x_cnt <= 11'd0;
            y_cnt <= 11'd0;
        end else if (per_frame_clken) begin
            if (x_cnt == IMG_HDISP - 11'd1) begin
                x_cnt <= 11'd0;
                if (y_cnt < IMG_VDISP)
                    y_cnt <= y_cnt + 11'd1;
            end else begin
                x_cnt <= x_cnt + 11'd1;
            end
        end
    end

    // One extra bit so coord + LINE_W never wraps near the image edge.
    logic [11:0] x12, y12, l12, r12, u12, d12, lw12;
    logic        in_box, on_edge, on_cross, draw;

    assign x12  = {1'b0, x_cnt};
    assign y12  = {1'b0, y_cnt};
    assign l12  = {1'b0, box.left};
    assign r12  = {1'b0, box.right};
    assign u12  = {1'b0, box.up};
    assign d12  = {1'b0, box.down};
    assign lw12 = {8'd0, LINE_W};

    assign in_box  = (y_cnt < IMG_VDISP) && (x12 >= l12) && (x12 <= r12) &&
                     (y12 >= u12) && (y12 <= d12);
    assign on_edge = (x12 < l12 + lw12) || (x12 + lw12 > r12) ||
                     (y12 < u12 + lw12) || (y12 + lw12 > d12);

`ifdef RECT_CROSSHAIR_EN
    logic [11:0] cx12, cy12, dx, dy;

    assign cx12     = {1'b0, cx};
    assign cy12     = {1'b0, cy};
    assign dx       = (x12 >= cx12) ? (x12 - cx12) : (cx12 - x12);
    assign dy       = (y12 >= cy12) ? (y12 - cy12) : (cy12 - y12);
    assign on_cross = ((y12 == cy12) && (dx <= 12'd8)) ||
                      ((x12 == cx12) && (dy <= 12'd8));
`else
    assign on_cross = 1'b0;
`endif

    assign draw = per_frame_clken && box_active && in_box && (on_edge || on_cross);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_data    <= 16'd0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            post_img_data    <= draw ? BOX_COLOR : per_img_data;
        end
    end

endmodule

// File: tb/tb_rect_overlay.sv
// Directed bench for rect_overlay on a reduced 40x30 frame with hand-placed check points.
module tb_rect_overlay;

    localparam int H = 40;
    localparam int V = 30;
`ifdef RECT_CROSSHAIR_EN
    localparam bit XH = 1'b1;
`else
    localparam bit XH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        per_frame_vsync = 1'b0;
    logic        per_frame_href = 1'b0;
    logic        per_frame_clken = 1'b0;
    logic [15:0] per_img_data = 16'h0;
    logic [10:0] rect_up = 11'd0;
    logic [10:0] rect_down = 11'd0;
    logic [10:0] rect_left = 11'd0;
    logic [10:0] rect_right = 11'd0;
    logic        rect_flag = 1'b0;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [15:0] post_img_data;
    logic        box_active;

    rect_overlay #(
        .IMG_HDISP (11'd40),
        .IMG_VDISP (11'd30)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_data     (per_img_data),
        .rect_up          (rect_up),
        .rect_down        (rect_down),
        .rect_left        (rect_left),
        .rect_right       (rect_right),
        .rect_flag        (rect_flag),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_data    (post_img_data),
        .box_active       (box_active)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] cap [0:V-1][0:H-1];
    logic        prev_pix = 1'b0;
    int          prev_x = 0;
    int          prev_y = 0;

    function automatic logic [15:0] pix(input int x, input int y);
        return 16'((y << 6) | x) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_pt(input string tag, input int x, input int y, input logic on);
        chk($sformatf("%s(%0d,%0d)", tag, x, y), cap[y][x], on ? 16'hF800 : pix(x, y));
    endtask

    task automatic set_box(input int u, input int d, input int l, input int r, input logic f);
        rect_up = 11'(u); rect_down = 11'(d); rect_left = 11'(l); rect_right = 11'(r);
        rect_flag = f;
    endtask

    task automatic step(input logic vs, input logic hr, input logic ck, input int x, input int y);
        @(posedge clk); #1;
        if (prev_pix) cap[prev_y][prev_x] = post_img_data;
        per_frame_vsync = vs;
        per_frame_href  = hr;
        per_frame_clken = ck;
        per_img_data    = ck ? pix(x, y) : 16'h0;
        prev_pix = ck; prev_x = x; prev_y = y;
    endtask

    // Streams one frame; optionally swaps the detector box at chg_line or stops mid-line at abort_line.
    task automatic frame(input logic exp_active, input int chg_line, input int abort_line);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("post_vsync_before", 16'(post_frame_vsync), 16'h0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        chk("post_vsync_after", 16'(post_frame_vsync), 16'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("box_active", 16'(box_active), 16'(exp_active));
        for (int y = 0; y < V; y++) begin
            if (y == chg_line) set_box(2, 8, 30, 38, 1'b1);
            for (int x = 0; x < H; x++) begin
                step(1'b0, 1'b1, 1'b1, x, y);
                if (y == 12 && x == 4) begin
                    chk("lat_href", 16'(post_frame_href), 16'h1);
                    chk("lat_clken", 16'(post_frame_clken), 16'h1);
                    chk("lat_data", post_img_data, pix(3, 12));
                end
                if (y == abort_line && x == 10) return;
            end
            step(1'b0, 1'b0, 1'b0, 0, 0);
            step(1'b0, 1'b0, 1'b0, 0, 0);
        end
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Box A: U=10 D=20 L=5 R=25, centre (15,15).
    task automatic chk_box_a(input string tag, input logic drawn);
        chk_pt(tag, 5, 10, drawn);
        chk_pt(tag, 25, 10, drawn);
        chk_pt(tag, 15, 11, drawn);
        chk_pt(tag, 15, 19, drawn);
        chk_pt(tag, 15, 20, drawn);
        chk_pt(tag, 5, 15, drawn);
        chk_pt(tag, 6, 15, drawn);
        chk_pt(tag, 24, 15, drawn);
        chk_pt(tag, 25, 20, drawn);
        chk_pt(tag, 4, 10, 1'b0);
        chk_pt(tag, 26, 10, 1'b0);
        chk_pt(tag, 15, 9, 1'b0);
        chk_pt(tag, 15, 21, 1'b0);
        chk_pt(tag, 7, 12, 1'b0);
        chk_pt(tag, 8, 13, 1'b0);
        chk_pt(tag, 23, 13, 1'b0);
        chk_pt(tag, 10, 15, drawn && XH);
        chk_pt(tag, 15, 13, drawn && XH);
        chk_pt(tag, 22, 15, drawn && XH);
        chk_pt(tag, 15, 18, drawn && XH);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #20;
        chk("rst_vsync", 16'(post_frame_vsync), 16'h0);
        chk("rst_href", 16'(post_frame_href), 16'h0);
        chk("rst_clken", 16'(post_frame_clken), 16'h0);
        chk("rst_data", post_img_data, 16'h0);
        chk("rst_active", 16'(box_active), 16'h0);
        @(negedge clk) rst_n = 1'b1;

        set_box(10, 20, 5, 25, 1'b1);
        frame(1'b1, -1, -1);
        chk_box_a("valid", 1'b1);

        set_box(10, 20, 5, 25, 1'b0);
        frame(1'b1, -1, -1);
        chk_box_a("miss1", 1'b1);
        frame(1'b1, -1, -1);
        frame(1'b1, -1, -1);
        chk_box_a("miss3", 1'b1);
        frame(1'b0, -1, -1);
        chk_box_a("miss4", 1'b0);

        set_box(10, 20, 5, 25, 1'b1);
        frame(1'b1, -1, -1);
        set_box(20, 10, 5, 25, 1'b1);
        frame(1'b1, -1, -1);
        chk_box_a("invalid", 1'b1);
        set_box(10, 20, 5, 25, 1'b0);
        frame(1'b1, -1, -1);
        frame(1'b1, -1, -1);
        chk_box_a("inv_miss3", 1'b1);
        frame(1'b0, -1, -1);
        chk_box_a("inv_miss4", 1'b0);

        set_box(10, 20, 5, 25, 1'b1);
        frame(1'b1, 5, -1);
        chk_box_a("midchg", 1'b1);
        chk_pt("midchg_b", 30, 5, 1'b0);
        frame(1'b1, -1, -1);
        chk_pt("new_b", 30, 5, 1'b1);
        chk_pt("new_b", 38, 8, 1'b1);
        chk_pt("new_b", 34, 2, 1'b1);
        chk_pt("new_b", 5, 15, 1'b0);
        chk_pt("new_b", 15, 11, 1'b0);

        set_box(10, 20, 5, 25, 1'b1);
        frame(1'b1, -1, 15);
        chk("pre_rst_href", 16'(post_frame_href), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_href", 16'(post_frame_href), 16'h0);
        chk("mid_rst_clken", 16'(post_frame_clken), 16'h0);
        chk("mid_rst_data", post_img_data, 16'h0);
        chk("mid_rst_active", 16'(box_active), 16'h0);
        per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_data = 16'h0;
        prev_pix = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        set_box(10, 20, 5, 25, 1'b0);
        frame(1'b0, -1, -1);
        chk_box_a("post_rst_nobox", 1'b0);
        set_box(10, 20, 5, 25, 1'b1);
        frame(1'b1, -1, -1);
        chk_box_a("post_rst_box", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
